atree_seq_sum: RTL and testbench
================================

Name: atree_seq_sum

Overview:
- Sequencing controller that reduces a wide unsigned vector through one shared adder tree (atree), one tree-width chunk per clock.
- Accepts a full vector on a valid/ready handshake and stores it locally.
- Walks the stored vector in CHUNKS passes through an internal atree instance and accumulates the partial sums.
- Presents the total on a valid/ready output port; sits between the operand buffers and the accumulate/activation stage of the accelerator datapath.

Parameters:
- IN_WIDTH, 8, width of each unsigned input element.
- LEVELS, 2, depth of the internal atree; chunk size is 2**LEVELS elements.
- CHUNKS, 4, chunks per vector (≥1); vector length N = CHUNKS*2**LEVELS.
- ACC_WIDTH (localparam), IN_WIDTH+LEVELS+$clog2(CHUNKS), with a minimum increment of 1 when CHUNKS=1; accumulator and output width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  [N-1:0][IN_WIDTH-1:0]  packed operand vector; element 0 is in the LSBs.
- out_valid  output  1  out_sum holds a completed total.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  ACC_WIDTH  unsigned sum of all N elements.
- busy  output  1  high in SUM or DONE.

Behaviour:
- Reset (async, active-high): state=IDLE, chunk index=0, accumulator=0, vector register=0. Outputs: out_valid=0, out_sum=0, busy=0, in_ready=0 while rst high. Reset mid-SUM or mid-DONE aborts; the partial result is discarded and never presented.
- in_ready = (state==IDLE) && !rst, combinational from state only; it does not depend on in_valid.
- IDLE: on in_valid && in_ready at edge E0, capture in_data, clear acc and idx, go to SUM.
  - in_valid while not IDLE is ignored, with no capture.
  - in_data changes after E0 do not affect the result.
- SUM: internal atree is fed chunk idx = elements [idx*2**LEVELS +: 2**LEVELS] of the stored vector. Each edge:
  - acc <= acc + zero-extended tree out; idx <= idx+1.
  - After the edge that adds chunk CHUNKS-1, go to DONE.
  - SUM lasts exactly CHUNKS cycles.
- DONE: out_valid=1; out_sum=acc, held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE, clear out_valid, clear out_sum to 0.
- Latency: out_valid first high CHUNKS cycles after E0, i.e. at edge E0+CHUNKS.
- Throughput: one vector per CHUNKS+2 cycles with out_ready held high: capture, CHUNKS sums, one DONE cycle, then back to IDLE.
- No overlap: a new vector is not accepted in the same cycle as the output handshake.
- Arithmetic:
  - All unsigned, no saturation; ACC_WIDTH is sized so the all-max input cannot overflow.
  - Tree out width is IN_WIDTH+LEVELS.
- CHUNKS=1: SUM lasts one cycle; behaviour otherwise identical.

Test Plan:
- Zeros (IN_WIDTH=8, LEVELS=2, CHUNKS=4, ACC_WIDTH=12): all-zero vector -> out_valid at E0+4, out_sum=0x000.
- All ones: every element 8'hFF -> out_sum=16*255=4080=0xFF0 at E0+4; busy high E0+1..E0+4.
- Mixed values: elements 0..15 = {9,27,89,26,101,37,46,93,89,93,52,98,79,88,47,23} -> out_sum=997=0x3E5.
  - Same values with in_data changed to zeros one cycle after E0 -> out_sum still 997.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_sum stable at its value, in_ready=0, and an in_valid pulse during DONE is ignored.
  - Raising out_ready -> out_valid falls next edge, in_ready rises.
  - A new vector of all 1s (element value 1) then yields out_sum=16.
- Reset mid-operation: assert rst asynchronously two cycles into SUM -> out_valid, busy, out_sum go 0 immediately without a clock edge.
  - After deassert, in_ready=1; the next vector of all 2s yields out_sum=32 with no residue from the aborted run.

Source files
------------

// File: rtl/atree_seq_sum.sv
// rtl/atree_seq_sum.sv - sequential vector reduction through one shared adder tree.
// Holds one captured vector and adds it into an accumulator one tree-width chunk per clock.

module atree #(
    parameter int IN_WIDTH = 8,
    parameter int LEVELS   = 2
) (
    input  logic [(2**LEVELS)*IN_WIDTH-1:0] data,
    output logic [IN_WIDTH+LEVELS-1:0]      sum
);
    localparam int OW = IN_WIDTH + LEVELS;

    genvar l, j;
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [OW-1:0] s [2**(LEVELS-l)];
        if (l == 0) begin : g_leaf
            for (j = 0; j < 2**LEVELS; j++) begin : g_in
                assign s[j] = OW'(data[j*IN_WIDTH +: IN_WIDTH]);
            end
        end else begin : g_add
            for (j = 0; j < 2**(LEVELS-l); j++) begin : g_pair
                assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LEVELS].s[0];
endmodule

module atree_seq_sum #(
    parameter int IN_WIDTH = 8,
    parameter int LEVELS   = 2,
    parameter int CHUNKS   = 4,
    localparam int CH        = 2**LEVELS,
    localparam int N         = CHUNKS * CH,
    localparam int ACC_WIDTH = IN_WIDTH + LEVELS + ((CHUNKS > 1) ? $clog2(CHUNKS) : 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0][IN_WIDTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_sum,
    output logic                         busy
);
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CW    = CH * IN_WIDTH;
    localparam int TW    = IN_WIDTH + LEVELS;

    typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] acc;
    logic [N*IN_WIDTH-1:0] vec;
    logic [CW-1:0]        chunk;
    logic [TW-1:0]        tree_sum;
    logic [ACC_WIDTH-1:0] acc_next;

    assign in_ready = (state == IDLE) && !rst;

    // Chunk mux in front of the single shared tree.
    always_comb begin
        chunk = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            if (idx == IDX_W'(c)) chunk = vec[c*CW +: CW];
        end
    end

    atree #(.IN_WIDTH(IN_WIDTH), .LEVELS(LEVELS)) u_tree (
        .data (chunk),
        .sum  (tree_sum)
    );

    assign acc_next = acc + ACC_WIDTH'(tree_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            vec       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec   <= in_data;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= SUM;
                    end
                end
                SUM: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(CHUNKS - 1)) begin
                        // The total leaves on the same edge that adds the last chunk.
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_sum   <= acc_next;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atree_seq_sum.sv
// tb/tb_atree_seq_sum.sv - scoreboard bench for atree_seq_sum.

module tb_atree_seq_sum;
    localparam int IN_WIDTH  = 8;
    localparam int LEVELS    = 2;
    localparam int CHUNKS    = 4;
    localparam int N         = CHUNKS * (2**LEVELS);
    localparam int ACC_WIDTH = 12;

    typedef logic [N-1:0][IN_WIDTH-1:0] vec_t;
    typedef struct {int sum; int e0;} exp_t;

    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_ready;
    vec_t in_data = '0;
    logic out_valid;
    logic out_ready = 1;
    logic [ACC_WIDTH-1:0] out_sum;
    logic busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_e0 = 0;
    bit check_tp = 0;
    bit rand_ready = 0;
    exp_t q[$];

    atree_seq_sum #(.IN_WIDTH(IN_WIDTH), .LEVELS(LEVELS), .CHUNKS(CHUNKS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int model_sum(input vec_t v);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic vec_t fill(input int val);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = IN_WIDTH'(val);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic send(input vec_t v, input bit zero_after);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1;
        in_data  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        in_data  = zero_after ? '0 : vec_t'({$urandom, $urandom, $urandom, $urandom});
        e.sum = model_sum(v);
        e.e0  = cyc;
        q.push_back(e);
        if (check_tp) chk("throughput", cyc - last_e0, CHUNKS + 2);
        last_e0 = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples 1 time unit after each falling edge.
    initial begin
        bit prev_valid = 0;
        bit prev_ready = 0;
        int held = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_valid = 0;
                continue;
            end
            chk("busy", busy, int'(q.size() != 0));
            chk("in_ready", in_ready, int'(q.size() == 0));
            if (!out_valid) chk("out_sum_idle", out_sum, 0);
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", cyc - q[0].e0, CHUNKS);
            end
            if (out_valid && prev_valid && !prev_ready) chk("hold_sum", out_sum, held);
            if (out_valid && out_ready && q.size() != 0) begin
                chk("sum", out_sum, q[0].sum);
                void'(q.pop_front());
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            held = out_sum;
        end
    end

    initial begin
        vec_t v;
        int mixed[16] = '{9, 27, 89, 26, 101, 37, 46, 93, 89, 93, 52, 98, 79, 88, 47, 23};
        int n;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        send(fill(0), 0);
        drain();
        send(fill(255), 0);
        drain();
        for (int i = 0; i < N; i++) v[i] = IN_WIDTH'(mixed[i]);
        chk("mixed_model", model_sum(v), 997);
        send(v, 1);
        drain();

        // Backpressure with an ignored in_valid pulse during DONE.
        out_ready = 0;
        send(v, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) in_valid = 1;
            @(negedge clk);
            in_valid = 0;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", out_sum, 997);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        drain();
        send(fill(1), 0);
        drain();

        // Asynchronous reset two cycles into SUM.
        send(fill(200), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1;
        q.delete();
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_sum", out_sum, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("after_rst_in_ready", in_ready, 1);
        @(negedge clk);
        send(fill(2), 0);
        drain();

        // Back-to-back vectors with out_ready held high.
        send(fill(3), 0);
        check_tp = 1;
        for (int k = 0; k < 3; k++) send(vec_t'({$urandom, $urandom, $urandom, $urandom}), 0);
        check_tp = 0;
        drain();

        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) v[i] = IN_WIDTH'($urandom_range(0, 255));
            if (k % 5 == 0) v = fill(255);
            send(v, 0);
        end
        drain();
        rand_ready = 0;
        out_ready = 1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
